ram_loader: RTL and testbench

RAM_LOADER -- requirements
Module: ram_loader

---
 rtl/hack_pkg.sv | 42 ++++
 rtl/ram_loader.sv | 205 ++++++++++++++++++++
 tb/tb_ram_loader.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/hack_pkg.sv
// Shared definitions for the RAM loader: bus widths, FSM state type and
// small state-decode helpers used to build the registered status outputs.
package hack_pkg;

    localparam int ADDR_W = 14;
    localparam int DATA_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_HI = 3'd1,
        ST_LEN_LO = 3'd2,
        ST_DAT_HI = 3'd3,
        ST_DAT_LO = 3'd4,
        ST_WRITE  = 3'd5,
        ST_CHK    = 3'd6,
        ST_DONE   = 3'd7
    } loader_state_t;

    // States in which a byte from the host link can be taken.
    function automatic logic state_takes_byte(input loader_state_t s);
        logic r;
        case (s)
            ST_LEN_HI, ST_LEN_LO, ST_DAT_HI, ST_DAT_LO, ST_CHK: r = 1'b1;
            default:                                          r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic state_is_busy(input loader_state_t s);
        logic r;
        case (s)
            ST_IDLE, ST_DONE: r = 1'b0;
            default:          r = 1'b1;
        endcase
        return r;
    endfunction

    function automatic logic [7:0] sum8(input logic [7:0] a, input logic [7:0] b);
        return 8'(a + b);
    endfunction

endpackage

// File: rtl/ram_loader.sv
// Streams a length-prefixed big-endian word image from a byte link into RAM,
// holding the CPU in reset meanwhile. Optional trailing checksum: RAM_LOADER_CHKSUM_EN.
module ram_loader
    import hack_pkg::*;
#(
    parameter int WORDS = 16384
) (
    input  logic              clock,
    input  logic              aclr_n,
    input  logic              start,
    input  logic [7:0]        s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] data,
    output logic              wren,
    output logic              busy,
    output logic              cpu_reset,
    output logic              done,
    output logic              err,
    output logic              chk_ok
);

    loader_state_t     r_state;
    loader_state_t     w_next_state;
    logic [7:0]        r_len_hi;
    logic [15:0]       r_len;
    logic [7:0]        r_word_hi;
    logic [ADDR_W-1:0] r_index;
    logic [ADDR_W-1:0] r_address;
    logic [DATA_W-1:0] r_data;
    logic              r_s_ready;
    logic              r_wren;
    logic              r_busy;
    logic              r_done;
    logic              r_err;
    logic              w_accept;
    logic [15:0]       w_len_full;
    logic              w_len_too_big;
    logic              w_last;

    assign w_accept      = s_valid & r_s_ready;
    assign w_len_full    = {r_len_hi, s_data};
    assign w_len_too_big = (17'(w_len_full) > 17'(WORDS));
    // r_len is at least 1 whenever WRITE is reachable, so r_len-1 never underflows there.
    assign w_last        = (16'(r_index) == 16'(r_len - 16'd1));

    // Next-state decode for the byte-assembly FSM.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_next_state = ST_LEN_HI;
                end else begin
                    w_next_state = r_state;
                end
            end
            ST_LEN_HI: begin
                if (w_accept) begin
                    w_next_state = ST_LEN_LO;
                end else begin
                    w_next_state = ST_LEN_HI;
                end
            end
            ST_LEN_LO: begin
                if (!w_accept) begin
                    w_next_state = ST_LEN_LO;
                end else if ((w_len_full == 16'd0) || w_len_too_big) begin
                    w_next_state = ST_DONE;
                end else begin
                    w_next_state = ST_DAT_HI;
                end
            end
            ST_DAT_HI: begin
                if (w_accept) begin
                    w_next_state = ST_DAT_LO;
                end else begin
                    w_next_state = ST_DAT_HI;
                end
            end
            ST_DAT_LO: begin
                if (w_accept) begin
                    w_next_state = ST_WRITE;
                end else begin
                    w_next_state = ST_DAT_LO;
                end
            end
            ST_WRITE: begin
                if (w_last) begin
`ifdef RAM_LOADER_CHKSUM_EN
                    w_next_state = ST_CHK;
`else
                    w_next_state = ST_DONE;
`endif
                end else begin
                    w_next_state = ST_DAT_HI;
                end
            end
            ST_CHK: begin
                if (w_accept) begin
                    w_next_state = ST_DONE;
                end else begin
                    w_next_state = ST_CHK;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // State register plus status flags registered from the next state so they align with it.
    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
            r_state   <= ST_IDLE;
            r_s_ready <= 1'b0;
            r_wren    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_s_ready <= state_takes_byte(w_next_state);
            r_wren    <= (w_next_state == ST_WRITE);
            r_busy    <= state_is_busy(w_next_state);
            r_done    <= (w_next_state == ST_DONE);
        end
    end

    // Length capture, word assembly, RAM address/data and error flag.
    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
            r_len_hi  <= 8'd0;
            r_len     <= 16'd0;
            r_word_hi <= 8'd0;
            r_index   <= {ADDR_W{1'b0}};
            r_address <= {ADDR_W{1'b0}};
            r_data    <= {DATA_W{1'b0}};
            r_err     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_index <= {ADDR_W{1'b0}};
                        r_err   <= 1'b0;
                    end
                end
                ST_LEN_HI: if (w_accept) r_len_hi <= s_data;
                ST_LEN_LO: begin
                    if (w_accept) begin
                        r_len <= w_len_full;
                        r_err <= w_len_too_big;
                    end
                end
                ST_DAT_HI: if (w_accept) r_word_hi <= s_data;
                ST_DAT_LO: begin
                    if (w_accept) begin
                        r_address <= r_index;
                        r_data    <= {r_word_hi, s_data};
                    end
                end
                // Index stops at N-1 <= WORDS-1, so the address cannot wrap.
                ST_WRITE: if (!w_last) r_index <= r_index + ADDR_W'(1);
                default: ;
            endcase
        end
    end

`ifdef RAM_LOADER_CHKSUM_EN
    logic [7:0] r_sum;
    logic       r_chk_ok;

    // Modulo-256 running sum of data bytes and the trailing-byte verdict.
    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
            r_sum    <= 8'd0;
            r_chk_ok <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_sum    <= 8'd0;
                        r_chk_ok <= 1'b0;
                    end
                end
                ST_DAT_HI, ST_DAT_LO: if (w_accept) r_sum <= sum8(r_sum, s_data);
                ST_CHK: if (w_accept) r_chk_ok <= (sum8(r_sum, s_data) == 8'h00);
                default: ;
            endcase
        end
    end

    assign chk_ok = r_chk_ok;
`else
    assign chk_ok = 1'b1;
`endif

    assign s_ready   = r_s_ready;
    assign wren      = r_wren;
    assign busy      = r_busy;
    assign cpu_reset = r_busy;
    assign done      = r_done;
    assign err       = r_err;
    assign address   = r_address;
    assign data      = r_data;

endmodule

// File: tb/tb_ram_loader.sv
// Scoreboard bench for ram_loader: stimulus queues expected RAM writes, a
// negedge monitor pops and compares on every wren pulse.
module tb_ram_loader;

    localparam int WORDS = 16384;

    logic        clock = 1'b0;
    logic        aclr_n;
    logic        start;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_ready;
    logic [13:0] address;
    logic [15:0] data;
    logic        wren;
    logic        busy;
    logic        cpu_reset;
    logic        done;
    logic        err;
    logic        chk_ok;

    ram_loader #(.WORDS(WORDS)) dut (
        .clock(clock), .aclr_n(aclr_n), .start(start), .s_data(s_data),
        .s_valid(s_valid), .s_ready(s_ready), .address(address), .data(data),
        .wren(wren), .busy(busy), .cpu_reset(cpu_reset), .done(done),
        .err(err), .chk_ok(chk_ok)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [13:0] a;
        logic [15:0] d;
    } wr_t;

    wr_t         exp_q[$];
    wr_t         mon_e;
    int          checks = 0;
    int          errors = 0;
    int          wr_count = 0;
    int          wr_base;
    int          exp_writes;
    logic        exp_err;
    logic        exp_chk;
    logic [15:0] tx_words [0:15];

`ifdef RAM_LOADER_CHKSUM_EN
    localparam logic CHK_RESET = 1'b0;
`else
    localparam logic CHK_RESET = 1'b1;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Every RAM write must match the oldest expected write.
    always @(negedge clock) begin
        if (aclr_n === 1'b1 && wren === 1'b1) begin
            wr_count++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr %0h data %0h expected no write", address, data);
            end else begin
                mon_e = exp_q.pop_front();
                check("write_addr", 32'(address), 32'(mon_e.a));
                check("write_data", 32'(data), 32'(mon_e.d));
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap, input bit chk_rdy);
        int t;
        for (int i = 0; i < gap; i++) begin
            @(negedge clock);
            if (chk_rdy) check("ready_while_waiting", 32'(s_ready), 32'd1);
        end
        @(negedge clock);
        s_valid = 1'b1;
        s_data  = b;
        t = 0;
        while (s_ready !== 1'b1 && t < 40) begin
            @(negedge clock);
            t++;
        end
        if (t >= 40) begin
            checks++;
            errors++;
            $display("FAIL handshake_timeout: got s_ready %0b expected 1", s_ready);
        end else begin
            @(posedge clock);
            #1;
        end
        s_valid = 1'b0;
    endtask

    // Reference: N words written at 0..N-1 iff 1<=N<=WORDS; err iff N>WORDS.
    task automatic run_load(input int n, input int nsend, input int gap, input bit fixed_gap, input int chk_mode);
        logic [15:0] nn;
        logic [7:0]  sum;
        logic [7:0]  cb;
        logic [15:0] w;
        bit          wr_ok;
        int          g;
        nn         = 16'(n);
        wr_ok      = (n >= 1) && (n <= WORDS);
        exp_err    = (n > WORDS);
        exp_writes = wr_ok ? nsend : 0;
        wr_base    = wr_count;
        sum        = 8'd0;
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        g = fixed_gap ? gap : int'($urandom_range(0, gap));
        send_byte(nn[15:8], g, fixed_gap);
        g = fixed_gap ? gap : int'($urandom_range(0, gap));
        send_byte(nn[7:0], g, fixed_gap);
        if (wr_ok) begin
            for (int i = 0; i < nsend; i++) begin
                w = tx_words[i];
                exp_q.push_back({i[13:0], w});
                sum = 8'(sum + w[15:8] + w[7:0]);
                g = fixed_gap ? gap : int'($urandom_range(0, gap));
                send_byte(w[15:8], g, fixed_gap);
                g = fixed_gap ? gap : int'($urandom_range(0, gap));
                send_byte(w[7:0], g, fixed_gap);
            end
        end
`ifdef RAM_LOADER_CHKSUM_EN
        if (wr_ok && nsend == n) begin
            if (chk_mode == 0)      cb = 8'(8'd0 - sum);
            else if (chk_mode == 1) cb = 8'($urandom);
            else                    cb = 8'(8'd1 - sum);
            exp_chk = (8'(sum + cb) == 8'h00);
            send_byte(cb, gap, 1'b0);
        end else begin
            exp_chk = 1'b0;
        end
`else
        exp_chk = 1'b1;
        if (chk_mode < 0) exp_chk = 1'b1;
`endif
    endtask

    task automatic finish_load(input string tag);
        int t;
        t = 0;
        while (done !== 1'b1 && t < 20) begin
            @(negedge clock);
            t++;
        end
        check({tag, "_done"},      32'(done), 32'd1);
        check({tag, "_busy"},      32'(busy), 32'd0);
        check({tag, "_cpu_reset"}, 32'(cpu_reset), 32'd0);
        check({tag, "_s_ready"},   32'(s_ready), 32'd0);
        check({tag, "_err"},       32'(err), 32'(exp_err));
        check({tag, "_chk_ok"},    32'(chk_ok), 32'(exp_chk));
        check({tag, "_writes"},    32'(wr_count - wr_base), 32'(exp_writes));
        check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int t;
        aclr_n  = 1'b0;
        start   = 1'b0;
        s_valid = 1'b0;
        s_data  = 8'd0;
        #12;
        check("rst_s_ready", 32'(s_ready), 32'd0);
        check("rst_wren",    32'(wren), 32'd0);
        check("rst_busy",    32'(busy), 32'd0);
        check("rst_cpu_rst", 32'(cpu_reset), 32'd0);
        check("rst_done",    32'(done), 32'd0);
        check("rst_err",     32'(err), 32'd0);
        check("rst_address", 32'(address), 32'd0);
        check("rst_data",    32'(data), 32'd0);
        check("rst_chk_ok",  32'(chk_ok), 32'(CHK_RESET));
        @(negedge clock);
        aclr_n = 1'b1;

        tx_words[0] = 16'h1234;
        tx_words[1] = 16'hABCD;
        run_load(2, 2, 0, 1'b0, 0);
        finish_load("two_words");

        run_load(0, 0, 1, 1'b0, 0);
        finish_load("len_zero");

        run_load(16385, 0, 1, 1'b0, 0);
        finish_load("len_over");

        tx_words[0] = 16'h0102;
        run_load(1, 1, 5, 1'b1, 0);
        finish_load("gapped_good_sum");

        run_load(1, 1, 2, 1'b0, 2);
        finish_load("bad_sum");

        // Abort after 3 of 5 words: reset mid-load, nothing resumes.
        for (int i = 0; i < 5; i++) tx_words[i] = 16'($urandom);
        run_load(5, 3, 1, 1'b0, 0);
        t = 0;
        while ((wr_count - wr_base) < 3 && t < 10) begin
            @(negedge clock);
            t++;
        end
        #2;
        aclr_n = 1'b0;
        #1;
        check("abort_busy",    32'(busy), 32'd0);
        check("abort_cpu_rst", 32'(cpu_reset), 32'd0);
        check("abort_s_ready", 32'(s_ready), 32'd0);
        check("abort_wren",    32'(wren), 32'd0);
        check("abort_done",    32'(done), 32'd0);
        check("abort_address", 32'(address), 32'd0);
        check("abort_chk_ok",  32'(chk_ok), 32'(CHK_RESET));
        repeat (2) @(negedge clock);
        aclr_n = 1'b1;
        repeat (5) @(negedge clock);
        check("abort_stays_idle", 32'(busy), 32'd0);
        check("abort_no_done",    32'(done), 32'd0);
        check("abort_writes",     32'(wr_count - wr_base), 32'd3);
        check("abort_queue",      32'(exp_q.size()), 32'd0);

        for (int k = 0; k < 25; k++) begin
            if ($urandom_range(0, 7) == 0) n = int'($urandom_range(WORDS + 1, 65535));
            else                           n = int'($urandom_range(0, 12));
            for (int i = 0; i < 16; i++) tx_words[i] = 16'($urandom);
            run_load(n, (n <= WORDS) ? n : 0, 3, 1'b0, int'($urandom_range(0, 1)));
            finish_load("random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
